// File: rtl/uart_rx_mmio.sv
// UART receiver (8N1) with a small byte FIFO behind DATA/STATUS MMIO read registers.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a parity check reported in STATUS bit 4.
module uart_rx_mmio #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_en,
  input  logic        rd_addr,
  output logic [15:0] rd_data,
  output logic        irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int DEPTH        = 1 << FIFO_AW;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2:0]         bit_cnt_reg;
  logic [7:0]         shift_reg;
  logic               rx_meta_reg, rx_s_reg, rx_prev_reg;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg, count_next;
  logic               overrun_reg, frame_err_reg;
  logic [15:0]        rd_data_reg;
  logic               irq_reg;

  logic rx_fall, stop_sample, push_req, push_ok, pop, full, not_empty;
  logic status_rd, overrun_evt, frame_evt, parity_ok, parity_err_bit;
  logic [15:0] status_word;

  assign rx_fall     = rx_prev_reg & ~rx_s_reg;
  assign stop_sample = (state_reg == STOP) && (cnt_reg == CNT_LAST);
  assign push_req    = stop_sample & rx_s_reg & parity_ok;
  assign frame_evt   = stop_sample & ~rx_s_reg;
  assign not_empty   = (count_reg != '0);
  assign full        = count_reg[FIFO_AW];
  assign pop         = rd_en & ~rd_addr & not_empty;
  assign push_ok     = push_req & (~full | pop);
  assign overrun_evt = push_req & full & ~pop;
  assign status_rd   = rd_en & rd_addr;
  assign status_word = {11'b0, parity_err_bit, full, frame_err_reg, overrun_reg, not_empty};

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad_reg, parity_err_reg, parity_evt;
  assign parity_evt     = (state_reg == PARITY) && (cnt_reg == CNT_LAST) && (rx_s_reg != ^shift_reg);
  assign parity_ok      = ~parity_bad_reg;
  assign parity_err_bit = parity_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      if ((state_reg == PARITY) && (cnt_reg == CNT_LAST))
        parity_bad_reg <= parity_evt;
      parity_err_reg <= (parity_err_reg & ~status_rd) | parity_evt;
    end
  end
`else
  assign parity_ok      = 1'b1;
  assign parity_err_bit = 1'b0;
`endif

  // Frame FSM: start bit checked mid-bit, then every later bit sampled one bit period apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          bit_cnt_reg <= '0;
          if (rx_fall) state_reg <= START;
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg   <= '0;
            state_reg <= rx_s_reg ? IDLE : DATA;
          end else cnt_reg <= cnt_reg + 1'b1;
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
`else
            if (bit_cnt_reg == 3'd7) state_reg <= STOP;
`endif
          end else cnt_reg <= cnt_reg + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= STOP;
          end else cnt_reg <= cnt_reg + 1'b1;
        end
`endif
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else cnt_reg <= cnt_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  // Sticky flags: a status read clears them, but an event in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      irq_reg       <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_next;
      irq_reg       <= (count_next != '0);
      overrun_reg   <= (overrun_reg & ~status_rd) | overrun_evt;
      frame_err_reg <= (frame_err_reg & ~status_rd) | frame_evt;
      if (rd_en)
        rd_data_reg <= rd_addr ? status_word : (not_empty ? {8'h00, mem[rd_ptr_reg]} : 16'h0000);
    end
  end

  assign rd_data = rd_data_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: directed frames plus random traffic checked against a queue-based model.
module tb_uart_rx_mmio;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic        rd_addr;
  logic [15:0] rd_data;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_mmio #(.CLK_FREQ(921600), .BAUD(115200), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: received bytes in arrival order plus the three sticky flags.
  logic [7:0] model_q[$];
  bit m_ovr, m_fe, m_pe;
  logic [15:0] last_rd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else
      $display("ok   %s: %h", tag, got);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mmio_read(input logic a, output logic [15:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    cyc(1);
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  task automatic read_data(input string tag);
    logic [15:0] d, exp;
    exp = (model_q.size() != 0) ? {8'h00, model_q.pop_front()} : 16'h0000;
    mmio_read(1'b0, d);
    check(tag, d, exp);
    check({tag, " irq"}, {15'b0, irq}, {15'b0, model_q.size() != 0});
    last_rd = exp;
  endtask

  task automatic read_status(input string tag);
    logic [15:0] d, exp;
    exp    = 16'h0000;
    exp[0] = (model_q.size() != 0);
    exp[1] = m_ovr;
    exp[2] = m_fe;
    exp[3] = (model_q.size() == DEPTH);
    exp[4] = m_pe;
    m_ovr = 0; m_fe = 0; m_pe = 0;
    mmio_read(1'b1, d);
    check(tag, d, exp);
    last_rd = exp;
  endtask

  // Drives one frame bit by bit; optionally strobes a DATA read on the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par,
                            input bit rd_at_stop, output logic [15:0] d_at);
    logic [10:0] bits;
    int nb;
`ifdef UART_RX_PARITY_EN
    bits = {stop, (^b) ^ bad_par, b, 1'b0};
    nb   = 11;
`else
    bits = {1'b0, stop, b, 1'b0};
    nb   = 10;
`endif
    d_at = 16'h0000;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      for (int j = 0; j < CPB; j++) begin
        if (rd_at_stop && i == nb - 1 && j == 6) begin
          rd_en   = 1'b1;
          rd_addr = 1'b0;
        end
        cyc(1);
        if (rd_en) begin
          rd_en = 1'b0;
          d_at  = rd_data;
        end
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] b, input bit stop, input bit bad_par,
                          input bit rd_at_stop, input int low_hold, input string tag);
    logic [15:0] got, exp_rd;
    bit bad_p;
`ifdef UART_RX_PARITY_EN
    bad_p = bad_par;
`else
    bad_p = 1'b0;
`endif
    send_frame(b, stop, bad_p, rd_at_stop, got);
    exp_rd = 16'h0000;
    if (rd_at_stop && model_q.size() != 0) exp_rd = {8'h00, model_q.pop_front()};
    if (bad_p) m_pe = 1;
    if (!stop) m_fe = 1;
    if (stop && !bad_p) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else m_ovr = 1;
    end
    if (!stop) begin
      cyc(low_hold);
      rx = 1'b1;
      cyc(4);
    end
    if (rd_at_stop) check({tag, " rd@stop"}, got, exp_rd);
    check({tag, " irq"}, {15'b0, irq}, {15'b0, model_q.size() != 0});
    $display("frame %s byte=%h stop=%0d par_bad=%0d rd=%0d", tag, b, stop, bad_p, rd_at_stop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int op;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; rd_addr = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("reset rd_data", rd_data, 16'h0000);
    check("reset irq", {15'b0, irq}, 16'h0000);
    read_status("idle status");
    read_data("idle data");

    do_frame(8'hA5, 1, 0, 0, 0, "A5");
    read_status("A5 status");
    read_data("A5 data");
    cyc(3);
    check("rd_data hold", rd_data, last_rd);

    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(16);
    read_status("glitch status");
    check("glitch irq", {15'b0, irq}, 16'h0000);

    for (int k = 1; k <= 5; k++) do_frame(8'(k), 1, 0, 0, 0, "ovr fill");
    read_status("overrun status");
    for (int k = 0; k < 4; k++) read_data("overrun drain");
    read_status("overrun cleared");

    do_frame(8'h3C, 0, 0, 0, 40, "3C badstop");
    read_status("frame_err status");
    read_status("frame_err cleared");

    for (int k = 0; k < 4; k++) do_frame(8'h10 + 8'(k), 1, 0, 0, 0, "full fill");
    do_frame(8'h77, 1, 0, 1, 0, "push+pop");
    read_status("push+pop status");
    for (int k = 0; k < 4; k++) read_data("push+pop drain");

    do_frame(8'h5A, 1, 0, 0, 0, "pre-reset");
    rx = 1'b0;
    cyc(20);
    rst = 1'b1;
    cyc(2);
    rx = 1'b1;
    rst = 1'b0;
    model_q.delete();
    m_ovr = 0; m_fe = 0; m_pe = 0;
    cyc(12);
    check("midframe reset irq", {15'b0, irq}, 16'h0000);
    read_status("midframe reset status");

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        b = 8'($urandom);
        do_frame(b, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 10), "rand");
      end else if (op <= 7)
        read_data("rand data");
      else
        read_status("rand status");
    end
    while (model_q.size() != 0) read_data("final drain");
    read_status("final status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
